// File: rtl/eru_pipe_adder.sv
// eru_pipe_adder: two-stage block-speculative adder with
// valid/ready streaming and serial block-by-block correction.
module eru_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  output logic             out_corr,
  output logic [CNTW-1:0]  err_cnt,
  output logic             busy
);

  localparam int NBLK = WIDTH / BLK;
  localparam int KW   = $clog2(NBLK);

  typedef enum logic {RUN = 1'b0, CORR = 1'b1} state_t;

  state_t           state_q;
  logic             s1_v_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             corr_q;
  logic [WIDTH:0]   fix_q;
  logic [WIDTH:0]   fix_d;
  logic             carry_q;
  logic [KW-1:0]    k_q;

  logic             s2_v_q;
  logic [WIDTH:0]   s2_sum_q;
  logic             s2_err_q;
  logic             s2_corr_q;
  logic [CNTW-1:0]  cnt_q;

  logic [WIDTH:0]   spec_sum;
  logic [WIDTH:0]   exact;
  logic             spec_err;
  logic [WIDTH-1:0] gsh;
  logic [KW-1:0]    cidx;
  logic             cin_c;
  logic [BLK:0]     tc;
  logic             last;
  logic             need_fix;
  logic             advance;
  logic             load;

  // generate bits shifted up one, so gsh[i] = g[i-1], gsh[0] = 0
  assign gsh = {a_q[WIDTH-2:0] & b_q[WIDTH-2:0], 1'b0};

  // speculative sum: each block's carry-in guessed from the window below it
  always_comb begin : spec_c
    logic [BLK:0] t;
    logic         cadd;
    logic         sel;
    logic         cin;
    int           lo;
    t = {1'b0, a_q[BLK-1:0]} + {1'b0, b_q[BLK-1:0]};
    spec_sum = '0;
    spec_sum[BLK-1:0] = t[BLK-1:0];
    cadd = 1'b0;
    sel  = 1'b0;
    cin  = 1'b0;
    lo   = 0;
    for (int k = 1; k < NBLK; k++) begin
      lo   = (k - 1) * BLK;
      t    = {1'b0, a_q[lo+:BLK]} + {1'b0, b_q[lo+:BLK]};
      cadd = t[BLK]
           | ((&(a_q[lo+:BLK] ^ b_q[lo+:BLK])) & gsh[lo]);
      sel  = gsh[lo+BLK] | ~(a_q[lo+BLK] | b_q[lo+BLK]);
      cin  = sel ? gsh[lo+BLK] : cadd;
      t    = {1'b0, a_q[lo+BLK+:BLK]}
           + {1'b0, b_q[lo+BLK+:BLK]}
           + {{BLK{1'b0}}, cin};
      spec_sum[lo+BLK+:BLK] = t[BLK-1:0];
      spec_sum[lo+BLK] = t[0]
        | (~a_q[lo+BLK] & ~b_q[lo+BLK] & cadd);
    end
    spec_sum[WIDTH] = t[BLK];
  end

  assign exact    = {1'b0, a_q} + {1'b0, b_q};
  assign spec_err = (spec_sum != exact);

  // one correction step: block 1 in the RUN cycle, block k_q in CORR
  always_comb begin : fix_c
    logic [BLK:0] t0;
    int           base;
    t0    = {1'b0, a_q[BLK-1:0]} + {1'b0, b_q[BLK-1:0]};
    cidx  = (state_q == RUN) ? KW'(1) : k_q;
    cin_c = (state_q == RUN) ? t0[BLK] : carry_q;
    base  = int'(cidx) * BLK;
    tc    = {1'b0, a_q[base+:BLK]}
          + {1'b0, b_q[base+:BLK]}
          + {{BLK{1'b0}}, cin_c};
    fix_d = (state_q == RUN) ? spec_sum : fix_q;
    fix_d[base+:BLK] = tc[BLK-1:0];
    last  = (cidx == KW'(NBLK - 1));
    if (last) fix_d[WIDTH] = tc[BLK];
  end

  assign need_fix = s1_v_q & mode_q & spec_err & ~corr_q;
  assign advance  = s1_v_q & (~s2_v_q | out_ready)
                  & (state_q == RUN) & ~need_fix;
  assign in_ready = ~(s1_v_q & ~advance) & (state_q == RUN);
  assign load     = in_valid & in_ready;

  // S1 operand register and serial correction FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      corr_q  <= 1'b0;
      fix_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      state_q <= RUN;
    end else begin
      if (load) begin
        s1_v_q <= 1'b1;
        a_q    <= in_a;
        b_q    <= in_b;
        mode_q <= in_mode;
        corr_q <= 1'b0;
      end else if (advance) begin
        s1_v_q <= 1'b0;
      end
      case (state_q)
        RUN: begin
          if (need_fix) begin
            fix_q   <= fix_d;
            carry_q <= tc[BLK];
            if (last) begin
              corr_q <= 1'b1;
            end else begin
              state_q <= CORR;
              k_q     <= KW'(2);
            end
          end
        end
        CORR: begin
          fix_q   <= fix_d;
          carry_q <= tc[BLK];
          k_q     <= k_q + KW'(1);
          if (last) begin
            corr_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // S2 result register, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_sum_q  <= '0;
      s2_err_q  <= 1'b0;
      s2_corr_q <= 1'b0;
    end else if (advance) begin
      s2_v_q    <= 1'b1;
      s2_sum_q  <= corr_q ? fix_q : spec_sum;
      s2_err_q  <= spec_err;
      s2_corr_q <= corr_q;
    end else if (out_ready) begin
      s2_v_q <= 1'b0;
    end
  end

  // saturating count of erroneous results leaving S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (s2_v_q & out_ready & s2_err_q & ~(&cnt_q)) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign out_valid = s2_v_q;
  assign out_sum   = s2_sum_q;
  assign out_err   = s2_err_q;
  assign out_corr  = s2_corr_q;
  assign err_cnt   = cnt_q;
  assign busy      = s1_v_q | s2_v_q | (state_q == CORR);

endmodule

// File: tb/tb_eru_pipe_adder.sv
// tb_eru_pipe_adder: scoreboard bench for the speculative adder,
// default 32/4 build plus a 16/8 build.
module tb_eru_pipe_adder;

  typedef struct {
    longint sum;
    bit     err;
    bit     corr;
    int     acc;
    int     lat;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_a = 0;
  logic [31:0] in_b = 0;
  logic        in_mode = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [32:0] out_sum;
  logic        out_err;
  logic        out_corr;
  logic [15:0] err_cnt;
  logic        busy;

  logic        v2 = 0;
  logic        r2;
  logic [15:0] a2 = 0;
  logic [15:0] b2 = 0;
  logic        m2 = 0;
  logic        ov2;
  logic        or2 = 1;
  logic [16:0] s2;
  logic        e2;
  logic        c2;
  logic [15:0] cnt2;
  logic        busy2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;
  exp_t q[$];
  exp_t q2[$];
  exp_t cur;
  bit   held = 0;

  eru_pipe_adder #(.WIDTH(32), .BLK(4), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err), .out_corr(out_corr),
    .err_cnt(err_cnt), .busy(busy)
  );

  eru_pipe_adder #(.WIDTH(16), .BLK(8), .CNTW(16)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(r2),
    .in_a(a2), .in_b(b2), .in_mode(m2),
    .out_valid(ov2), .out_ready(or2),
    .out_sum(s2), .out_err(e2), .out_corr(c2),
    .err_cnt(cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // speculative adder behaviour, block by block in plain integers
  function automatic longint model(longint a, longint b, int w, int bl);
    longint m = (longint'(1) << bl) - 1;
    longint s = 0;
    longint t, cadd, cin, ak, bk, pa, pb;
    bit     gtop, zero;
    int     nb = w / bl;
    for (int k = 0; k < nb; k++) begin
      ak = (a >> (k * bl)) & m;
      bk = (b >> (k * bl)) & m;
      cadd = 0;
      cin = 0;
      zero = 0;
      if (k > 0) begin
        pa = (a >> ((k - 1) * bl)) & m;
        pb = (b >> ((k - 1) * bl)) & m;
        cadd = (pa + pb) >> bl;
        if (k > 1 && (pa ^ pb) == m
            && (((a & b) >> ((k - 1) * bl - 1)) & 1) != 0)
          cadd = 1;
        gtop = (((a & b) >> (k * bl - 1)) & 1) != 0;
        zero = ((ak | bk) & 1) == 0;
        cin = (gtop || zero) ? longint'(gtop) : cadd;
      end
      t = ak + bk + cin;
      if (zero && cadd != 0) t = t | 1;
      s |= (t & m) << (k * bl);
      if (k == nb - 1) s |= (t >> bl) << w;
    end
    return s;
  endfunction

  function automatic exp_t mk(longint a, longint b, bit mode,
                              int w, int bl, int acc, int lat);
    exp_t   e;
    longint sp = model(a, b, w, bl);
    longint ex = a + b;
    e.err  = (sp != ex);
    e.corr = mode && e.err;
    e.sum  = e.corr ? ex : sp;
    e.acc  = acc;
    e.lat  = lat;
    return e;
  endfunction

  task automatic send(input longint a, input longint b,
                      input bit mode, input int lat);
    int n = 0;
    bit ok = 0;
    in_a = a[31:0];
    in_b = b[31:0];
    in_mode = mode;
    in_valid = 1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end else begin
      last_acc = cyc;
      q.push_back(mk(a, b, mode, 32, 4, cyc, lat));
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic send2(input longint a, input longint b, input bit mode);
    int n = 0;
    bit ok = 0;
    a2 = a[15:0];
    b2 = b[15:0];
    m2 = mode;
    v2 = 1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (r2) ok = 1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept2_timeout actual=0 required=1");
    end else begin
      q2.push_back(mk(a, b, mode, 16, 8, cyc, -1));
    end
    @(posedge clk);
    #1;
    v2 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || q2.size() > 0 || out_valid || ov2) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size() + q2.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic longint opb(longint a, int w);
    int     r = int'($urandom_range(0, 3));
    longint m = (longint'(1) << w) - 1;
    if (r == 0) return (~a ^ (longint'(1) << $urandom_range(0, w - 1))) & m;
    if (r == 1) return longint'($urandom_range(0, 15));
    return longint'($urandom) & m;
  endfunction

  // monitor for the 32/4 instance
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else if (out_valid) begin
      if (held) begin
        chk("hold_sum", longint'(out_sum), cur.sum);
        chk("hold_flags", longint'({out_err, out_corr}),
            longint'({cur.err, cur.corr}));
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h required=none", out_sum);
      end else begin
        cur = q.pop_front();
        chk("sum", longint'(out_sum), cur.sum);
        chk("flags", longint'({out_err, out_corr}),
            longint'({cur.err, cur.corr}));
        if (cur.lat >= 0) chk("latency", longint'(cyc - cur.acc), longint'(cur.lat));
      end
      if (out_ready) begin
        held = 0;
        if (cur.err) exp_cnt++;
      end else begin
        held = 1;
      end
    end else begin
      held = 0;
    end
  end

  // monitor for the 16/8 instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov2 && or2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out2 actual=%0h required=none", s2);
      end else begin
        e = q2.pop_front();
        chk("sum16", longint'(s2), e.sum);
        chk("flags16", longint'({e2, c2}), longint'({e.err, e.corr}));
        if (e.err) exp_cnt2++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int first;
    longint a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", longint'({out_sum, out_err, out_corr}), 0);
    chk("rst_cnt_busy", longint'({err_cnt, busy}), 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    send(64'h0000_000F, 64'h0000_0001, 0, 2);
    drain();
    send(64'h0000_0FFF, 64'h0000_0001, 0, 2);
    drain();
    chk("err_cnt_one", longint'(err_cnt), 1);
    send(64'h0000_0FFF, 64'h0000_0001, 1, 9);
    drain();
    send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, -1);
    drain();
    chk("err_cnt_dir", longint'(err_cnt), longint'(exp_cnt));

    for (int i = 0; i < 100; i++) begin
      a = longint'($urandom);
      b = opb(a, 32);
      send(a, b, 0, (i == 0) ? 2 : -1);
      if (i == 0) first = last_acc;
    end
    chk("throughput", longint'(last_acc - first), 99);
    drain();
    chk("err_cnt_stream", longint'(err_cnt), longint'(exp_cnt));

    for (int i = 0; i < 30; i++) begin
      a = longint'($urandom);
      send(a, opb(a, 32), 1'($urandom_range(0, 1)), -1);
    end
    drain();

    out_ready = 0;
    send(64'h11, 64'h22, 0, -1);
    send(64'h0FFF, 64'h1, 0, -1);
    in_a = 32'h33;
    in_b = 32'h44;
    in_mode = 0;
    in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(negedge clk);
    chk("bp_in_ready_rise", in_ready, 1);
    q.push_back(mk(64'h33, 64'h44, 0, 32, 4, cyc, -1));
    @(posedge clk);
    #1;
    in_valid = 0;
    drain();
    chk("err_cnt_bp", longint'(err_cnt), longint'(exp_cnt));

    send(64'h0000_0FFF, 64'h0000_0001, 1, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("corr_blocks_input", in_ready, 0);
    rst_n = 0;
    #1;
    q.delete();
    q2.delete();
    exp_cnt = 0;
    exp_cnt2 = 0;
    chk("mid_rst_valid_ready", longint'({out_valid, in_ready}), 1);
    chk("mid_rst_out", longint'({out_sum, out_err, out_corr}), 0);
    chk("mid_rst_cnt_busy", longint'({err_cnt, busy}), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    send(64'h1, 64'h2, 0, 2);
    drain();

    for (int i = 0; i < 80; i++) begin
      a = longint'($urandom_range(0, 65535));
      send2(a, opb(a, 16), 1'($urandom_range(0, 1)));
    end
    drain();
    chk("err_cnt16", longint'(cnt2), longint'(exp_cnt2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
